cnt_rx: RTL

Receiving end of the divided-clock counter link: samples a slow strobe clock `inclk` and a 4-bit count bus `in`, both generated in the same `clk` domain by the counter/divider block. It recovers each transmitted value, measures the strobe period in `clk` cycles, and locks once the stream is consistent. It then checks that every value increments by 1 mod 16 and that the period stays constant, counting violations. It sits beside the counter as its link monitor and data sink.

---
 rtl/cnt_rx.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cnt_rx.sv
// Link monitor for the divided-clock counter: recovers each strobed count value,
// measures the strobe period, locks onto a consistent stream and counts violations.
module cnt_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        inclk,
  input  logic [3:0]  in,
  output logic [3:0]  data,
  output logic        valid,
  output logic [31:0] period,
  output logic        locked,
  output logic        seq_err,
  output logic        per_err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        inclk_q, inclk_d;
  logic [31:0] pcnt_q, pcnt_d;
  logic [31:0] ref_q, ref_d;
  logic [31:0] period_q, period_d;
  logic [3:0]  data_q, data_d;
  logic [3:0]  prev_q, prev_d;
  logic        valid_q, valid_d;
  logic        seq_err_q, seq_err_d;
  logic        per_err_q, per_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        rise;
  logic        timeout;
  logic        bump;
  logic [3:0]  exp_val;

  always_comb begin
    state_d   = state_q;
    inclk_d   = inclk;
    ref_d     = ref_q;
    period_d  = period_q;
    data_d    = data_q;
    prev_d    = prev_q;
    valid_d   = 1'b0;
    seq_err_d = 1'b0;
    per_err_d = 1'b0;
    err_cnt_d = err_cnt_q;
    bump      = 1'b0;

    rise    = inclk & ~inclk_q;
    exp_val = prev_q + 4'd1;
    // 33-bit compare so 2*ref cannot overflow
    timeout = {1'b0, pcnt_q} > {ref_q, 1'b0};
    pcnt_d  = rise ? 32'd1 : ((&pcnt_q) ? pcnt_q : pcnt_q + 32'd1);

    if (rise) begin
      data_d   = in;
      valid_d  = 1'b1;
      period_d = pcnt_q;
      prev_d   = in;
    end

    case (state_q)
      IDLE: if (rise) state_d = SYNC;
      SYNC: begin
        if (rise) begin
          ref_d = pcnt_q;
          if (in == exp_val) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (rise) begin
          seq_err_d = (in != exp_val);
          per_err_d = (pcnt_q != ref_q);
          if (seq_err_d || per_err_d) begin
            bump    = 1'b1;
            state_d = SYNC;
          end
        end else if (timeout) begin
          per_err_d = 1'b1;
          bump      = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bump && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      inclk_q   <= 1'b0;
      pcnt_q    <= '0;
      ref_q     <= '0;
      period_q  <= '0;
      data_q    <= '0;
      prev_q    <= '0;
      valid_q   <= 1'b0;
      seq_err_q <= 1'b0;
      per_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      inclk_q   <= inclk_d;
      pcnt_q    <= pcnt_d;
      ref_q     <= ref_d;
      period_q  <= period_d;
      data_q    <= data_d;
      prev_q    <= prev_d;
      valid_q   <= valid_d;
      seq_err_q <= seq_err_d;
      per_err_q <= per_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign period  = period_q;
  assign locked  = (state_q == LOCKED);
  assign seq_err = seq_err_q;
  assign per_err = per_err_q;
  assign err_cnt = err_cnt_q;

endmodule
